// File: rtl/div_operand_sequencer.sv
// Feeds one operand pair into the shared-bus divider, returns the quotient; optional DIV_ZERO_CHECK_EN short-circuits x/0.
// Latency: start 1 cycle after accept, dividend/divisor in cycles 2/3, out_valid 1 cycle after div_done.
// Backpressure: in_ready only in IDLE; result held on out_valid until out_ready, then div_rst flushes the divider.
module div_operand_sequencer #(
   parameter int WIDTH        = 16,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_dividend,
   input  logic [WIDTH-1:0] in_divisor,
   output logic             div_start,
   output logic [WIDTH-1:0] div_data,
   input  logic             div_done,
   input  logic [WIDTH-1:0] div_quot,
   output logic             div_rst,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quot,
   output logic             out_err,
   output logic             busy
);

   localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_LOAD_A, S_LOAD_B, S_WAIT, S_RESP, S_FLUSH
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [CW-1:0]    flush_cnt;
   logic             flush_q;

`ifdef DIV_ZERO_CHECK_EN
   logic err_q;
   assign out_err = err_q;
`else
   assign out_err = 1'b0;
`endif

   // The divider must also sit in s0 for the whole time rst is held.
   assign div_rst = flush_q | rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         div_start <= 1'b0;
         div_data  <= '0;
         flush_q   <= 1'b0;
         flush_cnt <= '0;
         out_valid <= 1'b0;
         out_quot  <= '0;
`ifdef DIV_ZERO_CHECK_EN
         err_q     <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_q      <= in_dividend;
                  b_q      <= in_divisor;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
                  if (in_divisor == '0) begin
                     out_quot  <= '1;
                     err_q     <= 1'b1;
                     out_valid <= 1'b1;
                     state     <= S_RESP;
                  end else
`endif
                  begin
                     div_start <= 1'b1;
                     state     <= S_START;
                  end
               end
            end
            S_START: begin
               div_start <= 1'b0;
               div_data  <= a_q;
               state     <= S_LOAD_A;
            end
            S_LOAD_A: begin
               div_data <= b_q;
               state    <= S_LOAD_B;
            end
            S_LOAD_B: begin
               div_data <= '0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (div_done) begin
                  out_quot  <= div_quot;
`ifdef DIV_ZERO_CHECK_EN
                  err_q     <= 1'b0;
`endif
                  out_valid <= 1'b1;
                  state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  flush_q   <= 1'b1;
                  flush_cnt <= CW'(FLUSH_CYCLES - 1);
                  state     <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               if (flush_cnt == '0) begin
                  flush_q  <= 1'b0;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
                  state    <= S_IDLE;
               end else begin
                  flush_cnt <= flush_cnt - CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_operand_sequencer.sv
// Bench: drives operand pairs and plays the divider (samples div_data, answers with a/b after a random delay).
module tb_div_operand_sequencer;

   localparam int W  = 16;
   localparam int FL = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_dividend;
   logic [W-1:0] in_divisor;
   logic         div_start;
   logic [W-1:0] div_data;
   logic         div_done;
   logic [W-1:0] div_quot;
   logic         div_rst;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_quot;
   logic         out_err;
   logic         busy;

   int errors = 0;
   int checks = 0;
   int starts_seen = 0;
   int starts_exp = 0;

   logic         hold_mode = 1'b0;
   logic [W-1:0] nxt_a = '0;
   logic [W-1:0] nxt_b = '0;

   div_operand_sequencer #(.WIDTH(W), .FLUSH_CYCLES(FL)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_dividend(in_dividend), .in_divisor(in_divisor),
      .div_start(div_start), .div_data(div_data),
      .div_done(div_done), .div_quot(div_quot), .div_rst(div_rst),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_quot(out_quot), .out_err(out_err), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (div_start) starts_seen++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Inputs that must not matter while an operation is in flight.
   task automatic junk();
      if (hold_mode) begin
         in_valid    = 1'b1;
         in_dividend = nxt_a;
         in_divisor  = nxt_b;
      end else begin
         in_valid    = 1'($urandom);
         in_dividend = W'($urandom);
         in_divisor  = W'($urandom);
      end
      out_ready = 1'($urandom);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_div_rst", div_rst, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_start", div_start, 0);
      check("rst_data", div_data, 0);
      step();
      step();
      check("rst_div_rst_held", div_rst, 1);
      div_done = 1'b0;
      rst = 1'b0;
      #1;
      check("rst_release", div_rst, 0);
      check("rst_idle", in_ready, 1);
   endtask

   task automatic resp_flush(input logic [W-1:0] q, input logic e, input int stall, input int rst_phase);
      for (int i = 0; i <= stall; i++) begin
         check("resp_valid", out_valid, 1);
         check("resp_quot", out_quot, q);
         check("resp_err", out_err, e);
         check("resp_div_rst", div_rst, 0);
         check("resp_in_ready", in_ready, 0);
         check("resp_data", div_data, 0);
         if (rst_phase == 2 && i == stall) begin
            do_reset();
            return;
         end
         junk();
         out_ready = (i == stall);
         step();
      end
      div_done = 1'b0;
      for (int i = 0; i < FL; i++) begin
         check("flush_div_rst", div_rst, 1);
         check("flush_valid", out_valid, 0);
         check("flush_in_ready", in_ready, 0);
         check("flush_busy", busy, 1);
         junk();
         step();
      end
      check("idle_in_ready", in_ready, 1);
      check("idle_busy", busy, 0);
      check("idle_div_rst", div_rst, 0);
      check("idle_quot_hold", out_quot, q);
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int lat, input int stall, input int rst_phase);
      logic [W-1:0] q;
      int n;
      q = (b != 0) ? a / b : '1;
      in_valid    = 1'b1;
      in_dividend = a;
      in_divisor  = b;
      n = 0;
      while (!in_ready && n < 40) begin
         step();
         n++;
      end
      if (!in_ready) begin
         check("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      step();
      junk();
`ifdef DIV_ZERO_CHECK_EN
      if (b == 0) begin
         check("dz_no_start", div_start, 0);
         check("dz_busy", busy, 1);
         resp_flush(q, 1'b1, stall, rst_phase);
         return;
      end
`endif
      starts_exp++;
      check("start", div_start, 1);
      check("start_busy", busy, 1);
      check("start_in_ready", in_ready, 0);
      check("start_data", div_data, 0);
      div_done = 1'($urandom);
      div_quot = W'($urandom);
      step();
      check("load_a", div_data, a);
      check("start_len", div_start, 0);
      junk();
      div_done = 1'($urandom);
      step();
      check("load_b", div_data, b);
      junk();
      div_done = 1'($urandom);
      step();
      div_done = 1'b0;
      if (b == 0) begin
         for (int i = 0; i < 30; i++) begin
            check("zero_hang_valid", out_valid, 0);
            check("zero_hang_busy", busy, 1);
            junk();
            step();
         end
         do_reset();
         return;
      end
      for (int i = 0; i < lat; i++) begin
         if (rst_phase == 1 && i == lat / 2) begin
            do_reset();
            return;
         end
         check("wait_valid", out_valid, 0);
         check("wait_data", div_data, 0);
         check("wait_start", div_start, 0);
         junk();
         step();
      end
      div_done = 1'b1;
      div_quot = q;
      step();
      div_quot = W'($urandom);
      resp_flush(q, 1'b0, stall, rst_phase);
   endtask

   task automatic idle_cycles(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         div_done  = 1'($urandom);
         div_quot  = W'($urandom);
         out_ready = 1'($urandom);
         step();
         check("idle_ignore_done", out_valid, 0);
         check("idle_busy_low", busy, 0);
      end
      div_done = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_dividend = '0;
      in_divisor = '0;
      div_done = 1'b0;
      div_quot = '0;
      out_ready = 1'b0;
      #2;
      check("reset_in_ready", in_ready, 1);
      check("reset_busy", busy, 0);
      check("reset_start", div_start, 0);
      check("reset_data", div_data, 0);
      check("reset_div_rst", div_rst, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_quot", out_quot, 0);
      check("reset_out_err", out_err, 0);
      step();
      step();
      rst = 1'b0;
      #1;
      check("reset_release", div_rst, 0);

      do_op(16'd100, 16'd7, 3, 0, 0);

      hold_mode = 1'b1;
      nxt_a = 16'd9;
      nxt_b = 16'd9;
      do_op(16'd5, 16'd9, 2, 0, 0);
      hold_mode = 1'b0;
      do_op(16'd9, 16'd9, 1, 0, 0);

      do_op(16'd1000, 16'd10, 5, 8, 0);

      hold_mode = 1'b1;
      nxt_a = 16'd50;
      nxt_b = 16'd5;
      do_op(16'd200, 16'd8, 6, 1, 0);
      hold_mode = 1'b0;
      idle_cycles(3);

      do_op(16'd60000, 16'd3, 6, 0, 1);
      do_op(16'd20, 16'd4, 2, 0, 0);

      do_op(16'd4321, 16'd17, 0, 3, 2);
      idle_cycles(2);

      do_op(16'd77, 16'd0, 2, 1, 0);
      do_op(16'd300, 16'd7, 2, 0, 0);

      for (int k = 0; k < 20; k++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = W'($urandom);
         rb = (k % 3 == 0) ? W'($urandom_range(1, 65535)) : W'($urandom_range(1, 300));
         do_op(ra, rb, int'($urandom_range(0, 8)), int'($urandom_range(0, 3)), 0);
         if (k % 4 == 0) idle_cycles(int'($urandom_range(1, 3)));
      end

      idle_cycles(2);
      check("start_pulse_count", starts_seen, starts_exp);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/div_operand_sequencer.md
# div_operand_sequencer

Upstream feeder for the shared-bus `division` datapath and its `controlpathD1` sequencer. It accepts one dividend/divisor pair through a valid/ready handshake and pulses `start`. It then drives the dividend and divisor onto the divider's `data_in` bus in the two cycles the divider's control path loads them. It waits for `done`, captures the quotient from `cout`, and returns it downstream through a valid/ready handshake. Between operations it forces the divider back to its idle state, because the divider's terminal state never exits on its own.

## Interface
Parameters:
- `WIDTH`, 16, operand and quotient width; must match the divider bus.
- `FLUSH_CYCLES`, 2, number of cycles `div_rst` is held after each result is consumed; minimum 1.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  operand pair is valid.
- `in_ready`  out  1  high only in IDLE.
- `in_dividend`  in  WIDTH  dividend.
- `in_divisor`  in  WIDTH  divisor.
- `div_start`  out  1  drives the divider control path's `start`.
- `div_data`  out  WIDTH  drives the divider's `data_in` bus.
- `div_done`  in  1  divider's `done`.
- `div_quot`  in  WIDTH  divider's `cout`.
- `div_rst`  out  1  divider control-path reset (forces state s0).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_quot`  out  WIDTH  quotient.
- `out_err`  out  1  divide-by-zero flag (see Configuration).
- `busy`  out  1  high in every state other than IDLE.

## Operation
- Operands are captured into internal `a_q`/`b_q` registers on `in_valid && in_ready`.
- State machine:
  - IDLE: `in_ready=1`. On accept, go to START.
  - START: `div_start=1` for exactly 1 cycle; go to LOAD_A.
  - LOAD_A: `div_data=a_q`; go to LOAD_B.
  - LOAD_B: `div_data=b_q`; go to WAIT.
  - WAIT: on sampling `div_done=1`, capture `div_quot` into `out_quot`; go to RESP.
  - RESP: `out_valid=1`. On `out_ready`, go to FLUSH.
  - FLUSH: `div_rst=1` for FLUSH_CYCLES cycles, then IDLE.
- `div_data` is 0 in every state except LOAD_A and LOAD_B.
- `out_quot` and `out_err` hold their values from capture until the next capture.
- No operand overlap: exactly one operation is in flight at a time.
- Unsigned arithmetic only. The quotient is taken verbatim from the divider; no width extension or truncation is applied.

## Timing
- Reset values:
  - state = IDLE.
  - `in_ready=1`, `busy=0`.
  - `div_start=0`, `div_data=0`.
  - `div_rst=1` while `rst` is asserted, then 0.
  - `out_valid=0`, `out_quot=0`, `out_err=0`.
- Cycle alignment (accept edge = cycle 0):
  - Cycle 1: `div_start` is high; the divider leaves s0.
  - Cycle 2: dividend is on `div_data`; the divider's `ldp` loads it.
  - Cycle 3: divisor is on `div_data`; the divider's `ldb`/`lda` load it.
- `out_valid` rises 1 cycle after `div_done` is first sampled high.
- Minimum accept-to-accept interval is 5 + divider loop time + output stall + FLUSH_CYCLES.
- `out_valid` and `out_quot` are stable while `out_ready=0` (no retraction).
- `in_valid` arriving while busy is ignored; `in_ready` stays 0 until IDLE.
- `div_done` outside WAIT is ignored.
- `rst` mid-operation (any state) returns to IDLE immediately:
  - `out_valid` drops.
  - The partially loaded operation is discarded.
  - `div_rst` is asserted for the duration of `rst`.

## Configuration
- `DIV_ZERO_CHECK_EN` defined:
  - On accept with `in_divisor==0`, the block skips START through WAIT and goes directly to RESP.
  - Result is `out_quot={WIDTH{1'b1}}`, `out_err=1`.
  - `div_start` is never pulsed for that operation, and FLUSH is still executed.
  - `out_err=0` for nonzero divisors.
- `DIV_ZERO_CHECK_EN` not defined:
  - A zero divisor is forwarded to the divider unchanged, and `out_err` is tied 0.
  - Such an operation never completes; only `rst` recovers the block.

## Test plan
- 100/7 with `out_ready=1` -> `div_data` = 100 in cycle 2 and 7 in cycle 3; `out_quot=14`, `out_err=0`; `div_rst` high for 2 cycles; `in_ready` returns to 1.
- 5/9 -> `out_quot=0`. Then 9/9 back-to-back (`in_valid` held high) -> second accept only after FLUSH; `out_quot=1`.
- 1000/10 with `out_ready=0` for 8 cycles after `out_valid` -> `out_valid` and `out_quot=100` held constant; FLUSH starts only after the `out_ready` cycle.
- `in_valid` pulsed during WAIT with operands 50/5 -> ignored; the current result is unaffected and no second `div_start` is seen.
- `rst` asserted during WAIT of 60000/3 -> `out_valid=0`, state IDLE, `div_rst=1` during reset. A following 20/4 -> `out_quot=5`.
- 77/0 with `DIV_ZERO_CHECK_EN` -> no `div_start`; `out_quot=16'hFFFF` and `out_err=1` 1 cycle after accept. Without the macro -> `div_start` pulses and `out_valid` stays 0 until `rst`.
